// File: rtl/mem_ctrl.sv
// Shares one 8-bit RAM port between instruction fetch and load/store, serialising into byte transfers.
// Optional one-entry fetch buffer: define MEM_CTRL_IF_BUF_EN.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        mem_req,
    input  logic        mem_wr,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [7:0]  ram_din,
    output logic [31:0] ram_a,
    output logic [7:0]  ram_dout,
    output logic        ram_wr,
    output logic [31:0] if_inst,
    output logic        if_done,
    output logic [31:0] mem_rdata,
    output logic        mem_done
);

    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state, state_nx;
    logic [31:0] base_q, wdata_q, asm_q, rd_word;
    logic [2:0]  cnt_q, len_q, req_len;
    logic [1:0]  rcv_idx;
    logic        issue, buf_hit;

`ifdef MEM_CTRL_IF_BUF_EN
    logic        buf_valid_q;
    logic [31:0] buf_tag_q;
    assign buf_hit = buf_valid_q && (if_addr == buf_tag_q);
`else
    assign buf_hit = 1'b0;
`endif

    assign req_len = (mem_len == 2'b00) ? 3'd1 : (mem_len == 2'b01) ? 3'd2 : 3'd4;

    // The receive index lags issue by one, so byte cnt-1 is on ram_din now.
    assign rcv_idx = cnt_q[1:0] - 2'd1;
    assign rd_word = asm_q | ({24'b0, ram_din} << {rcv_idx, 3'b000});

    always_comb begin
        // NOTE: defaults first, so no path through this block leaves a value unassigned (no latches).
        state_nx = state;
        case (state)
            IDLE: begin
                if (mem_req)     state_nx = mem_wr ? MEM_WR : MEM_RD;
                else if (if_req) state_nx = buf_hit ? DONE : IF_RD;
            end
            IF_RD, MEM_RD: if (cnt_q == len_q)         state_nx = DONE;
            MEM_WR:        if (cnt_q == len_q - 3'd1)  state_nx = DONE;
            DONE:          state_nx = IDLE;
            default:       state_nx = IDLE;
        endcase
    end

    // RAM outputs are gated by rst so an aborted store writes nothing in the reset cycle.
    always_comb begin
        issue    = (((state == IF_RD) || (state == MEM_RD)) && (cnt_q < len_q)) || (state == MEM_WR);
        ram_a    = 32'd0;
        ram_dout = 8'd0;
        ram_wr   = 1'b0;
        if (issue && !rst) ram_a = base_q + {29'd0, cnt_q};
        if ((state == MEM_WR) && !rst) begin
            ram_wr   = 1'b1;
            ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all sequential state, so every flop sees pre-edge values.
            state     <= IDLE;
            cnt_q     <= 3'd0;
            len_q     <= 3'd0;
            base_q    <= 32'd0;
            wdata_q   <= 32'd0;
            asm_q     <= 32'd0;
            if_inst   <= NOP;
            mem_rdata <= 32'd0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
`ifdef MEM_CTRL_IF_BUF_EN
            buf_valid_q <= 1'b0;
            buf_tag_q   <= 32'd0;
`endif
        end else begin
            state    <= state_nx;
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt_q <= 3'd0;
                    asm_q <= 32'd0;
                    if (mem_req) begin
                        base_q  <= mem_addr;
                        len_q   <= req_len;
                        wdata_q <= mem_wdata;
`ifdef MEM_CTRL_IF_BUF_EN
                        if (mem_wr) buf_valid_q <= 1'b0;
`endif
                    end else if (if_req) begin
                        base_q <= if_addr;
                        len_q  <= 3'd4;
                        if (buf_hit) if_done <= 1'b1;
                    end
                end
                IF_RD, MEM_RD: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q != 3'd0) asm_q <= rd_word;
                    if (cnt_q == len_q) begin
                        if (state == IF_RD) begin
                            if_inst <= rd_word;
                            if_done <= 1'b1;
`ifdef MEM_CTRL_IF_BUF_EN
                            buf_valid_q <= 1'b1;
                            buf_tag_q   <= base_q;
`endif
                        end else begin
                            mem_rdata <= rd_word;
                            mem_done  <= 1'b1;
                        end
                    end
                end
                MEM_WR: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == len_q - 3'd1) mem_done <= 1'b1;
                end
                default: cnt_q <= 3'd0;
            endcase
        end
    end

endmodule
